// File: rtl/regfile_wb_arbiter.sv
// rtl/regfile_wb_arbiter.sv - register-file write port shared by pipeline WB (A) and a queued multi-cycle unit (B)
// A wins by default; a saturating starvation counter forces the B FIFO head through.
module regfile_wb_arbiter #(
  parameter int DEPTH        = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    a_valid,
  output logic                    a_ready,
  input  logic [4:0]              a_reg,
  input  logic [31:0]             a_data,
  input  logic                    b_valid,
  output logic                    b_ready,
  input  logic [4:0]              b_reg,
  input  logic [31:0]             b_data,
  output logic                    EnableWrite,
  output logic [4:0]              write_reg,
  output logic [31:0]             write_data,
  output logic [$clog2(DEPTH):0]  fifo_count
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam int PW = $clog2(DEPTH);
  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0] FULL_CNT   = CW'(DEPTH);
  localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);

  logic [36:0]   mem_q [DEPTH];
  logic [PW-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [SW-1:0] starve_q, starve_d;
  logic          we_q, we_d;
  logic [4:0]    wreg_q, wreg_d;
  logic [31:0]   wdata_q, wdata_d;

  logic        empty, full, force_b, grant_a, grant_b, push;
  logic [36:0] head;
  logic [4:0]  sel_reg;
  logic [31:0] sel_data;

  always_comb begin
    empty    = (count_q == '0);
    full     = (count_q == FULL_CNT);
    force_b  = !empty && (starve_q == STARVE_MAX);
    a_ready  = !rst && !force_b;
    b_ready  = !rst && !full;
    grant_a  = a_ready && a_valid;
    grant_b  = !rst && !empty && (force_b || !a_valid);
    push     = b_valid && b_ready;
    head     = mem_q[rd_ptr_q];
    sel_reg  = grant_a ? a_reg  : head[36:32];
    sel_data = grant_a ? a_data : head[31:0];

    // Writes to r0 are consumed but never reach the register file.
    we_d    = (grant_a || grant_b) && (sel_reg != 5'd0);
    wreg_d  = we_d ? sel_reg  : wreg_q;
    wdata_d = we_d ? sel_data : wdata_q;

    rd_ptr_d = grant_b ? rd_ptr_q + PW'(1) : rd_ptr_q;
    wr_ptr_d = push    ? wr_ptr_q + PW'(1) : wr_ptr_q;
    count_d  = count_q;
    if (push && !grant_b)      count_d = count_q + CW'(1);
    else if (!push && grant_b) count_d = count_q - CW'(1);

    starve_d = starve_q;
    if (empty || grant_b)                        starve_d = '0;
    else if (grant_a && starve_q != STARVE_MAX)  starve_d = starve_q + SW'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      starve_q <= '0;
      we_q     <= 1'b0;
      wreg_q   <= '0;
      wdata_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      starve_q <= starve_d;
      we_q     <= we_d;
      wreg_q   <= wreg_d;
      wdata_q  <= wdata_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= {b_reg, b_data};
  end

  assign EnableWrite = we_q;
  assign write_reg   = wreg_q;
  assign write_data  = wdata_q;
  assign fifo_count  = count_q;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// tb/tb_regfile_wb_arbiter.sv - scoreboard bench for regfile_wb_arbiter
// A queue-level reference model predicts handshakes and writes; a monitor matches presented writes.
module tb_regfile_wb_arbiter;

  localparam int DEPTH = 2;
  localparam int LIM   = 4;

  logic        clk, rst;
  logic        a_valid, a_ready, b_valid, b_ready, EnableWrite;
  logic [4:0]  a_reg, b_reg, write_reg;
  logic [31:0] a_data, b_data, write_data;
  logic [$clog2(DEPTH):0] fifo_count;

  regfile_wb_arbiter #(.DEPTH(DEPTH), .STARVE_LIMIT(LIM)) dut (
    .clk(clk), .rst(rst),
    .a_valid(a_valid), .a_ready(a_ready), .a_reg(a_reg), .a_data(a_data),
    .b_valid(b_valid), .b_ready(b_ready), .b_reg(b_reg), .b_data(b_data),
    .EnableWrite(EnableWrite), .write_reg(write_reg), .write_data(write_data),
    .fifo_count(fifo_count)
  );

  typedef struct { logic [4:0] r; logic [31:0] d; } ent_t;
  typedef struct { logic [4:0] r; logic [31:0] d; int cyc; } wr_t;

  ent_t model_fifo[$];
  wr_t  exp_q[$];
  int   starve = 0;
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;
  logic [4:0]  held_reg = '0;
  logic [31:0] held_data = '0;
  logic        rst_prev = 1'b0;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h cycle=%0d", name, act, exp, cyc);
    end
  endtask

  // Reference model: decides acceptance and grants from the arbitration rules.
  always @(negedge clk) begin
    bit ne, fb, ar, br, ga, gb;
    ent_t e;
    chk("fifo_count", 32'(fifo_count), 32'(model_fifo.size()));
    if (rst) begin
      chk("a_ready_rst", 32'(a_ready), 32'd0);
      chk("b_ready_rst", 32'(b_ready), 32'd0);
      model_fifo.delete();
      starve = 0;
    end else begin
      ne = model_fifo.size() != 0;
      fb = ne && (starve == LIM);
      ar = !fb;
      br = model_fifo.size() < DEPTH;
      chk("a_ready", 32'(a_ready), 32'(ar));
      chk("b_ready", 32'(b_ready), 32'(br));
      ga = ar && a_valid;
      gb = ne && (fb || !a_valid);
      if (ga) begin
        if (a_reg != 0) exp_q.push_back('{a_reg, a_data, cyc + 1});
        starve = ne ? ((starve < LIM) ? starve + 1 : LIM) : 0;
      end
      if (gb) begin
        e = model_fifo.pop_front();
        if (e.r != 0) exp_q.push_back('{e.r, e.d, cyc + 1});
        starve = 0;
      end
      if (!ne) starve = 0;
      if (b_valid && br) model_fifo.push_back('{b_reg, b_data});
    end
  end

  // Monitor: every presented write must be the next expected one, in its cycle.
  always @(negedge clk) begin
    wr_t w;
    if (rst_prev) begin
      held_reg  = '0;
      held_data = '0;
    end
    rst_prev = rst;
    if (EnableWrite) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_write_reg", 32'(write_reg), 32'hFFFF_FFFF);
      end else begin
        w = exp_q.pop_front();
        chk("write_reg", 32'(write_reg), 32'(w.r));
        chk("write_data", write_data, w.d);
        chk("write_cycle", 32'(cyc), 32'(w.cyc));
        held_reg  = w.r;
        held_data = w.d;
      end
    end else if (exp_q.size() != 0 && exp_q[0].cyc <= cyc) begin
      w = exp_q.pop_front();
      chk("missing_write_en", 32'(EnableWrite), 32'd1);
    end
    chk("held_reg", 32'(write_reg), 32'(held_reg));
    chk("held_data", write_data, held_data);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_a(input logic v, input logic [4:0] r, input logic [31:0] d);
    a_valid = v; a_reg = r; a_data = d;
  endtask

  task automatic set_b(input logic v, input logic [4:0] r, input logic [31:0] d);
    b_valid = v; b_reg = r; b_data = d;
  endtask

  task automatic idle(input int n);
    set_a(0, 0, 0);
    set_b(0, 0, 0);
    repeat (n) tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit acc;
    rst = 1'b1;
    set_a(0, 0, 0);
    set_b(0, 0, 0);
    tick();
    tick();
    chk("rst_enable", 32'(EnableWrite), 32'd0);
    chk("rst_write_reg", 32'(write_reg), 32'd0);
    chk("rst_count", 32'(fifo_count), 32'd0);
    rst = 1'b0;
    idle(2);

    // A only
    set_a(1, 5'd9, 32'h29);
    tick();
    idle(3);

    // B fill with A held high
    set_a(1, 5'd3, 32'h100); set_b(1, 5'd19, 32'd5);  tick();
    set_a(1, 5'd4, 32'h101); set_b(1, 5'd20, 32'd15); tick();
    set_a(1, 5'd5, 32'h102); set_b(1, 5'd21, 32'd40); tick();
    chk("fill_count", 32'(fifo_count), 32'd2);
    set_a(0, 0, 0);
    acc = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      acc = b_ready;
      tick();
      if (acc) break;
    end
    chk("b21_accepted", 32'(acc), 32'd1);
    idle(5);

    // Starvation
    set_b(1, 5'd10, 32'd4); tick();
    set_b(0, 0, 0);
    for (int i = 0; i < 8; i++) begin
      set_a(1, 5'(i + 1), 32'h200 + 32'(i));
      tick();
    end
    idle(4);

    // Register 0 from both sides
    set_a(1, 5'd0, 32'hFF); tick();
    set_a(0, 0, 0); set_b(1, 5'd0, 32'h77); tick();
    idle(4);

    // Reset mid-operation with FIFO full and A granted
    set_a(1, 5'd7, 32'h300); set_b(1, 5'd11, 32'h31); tick();
    set_a(1, 5'd8, 32'h301); set_b(1, 5'd12, 32'h32); tick();
    set_a(1, 5'd9, 32'h302); set_b(0, 0, 0); tick();
    rst = 1'b1; tick();
    rst = 1'b0;
    chk("midrst_count", 32'(fifo_count), 32'd0);
    idle(4);

    // Random traffic
    for (int i = 0; i < 2000; i++) begin
      set_a($urandom_range(0, 99) < 60, ($urandom_range(0, 9) == 0) ? 5'd0 : 5'($urandom_range(1, 31)), $urandom);
      set_b($urandom_range(0, 99) < 45, ($urandom_range(0, 9) == 0) ? 5'd0 : 5'($urandom_range(1, 31)), $urandom);
      rst = ($urandom_range(0, 299) == 0);
      tick();
    end
    rst = 1'b0;
    idle(10);
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
